// File: rtl/ram_arbiter_128x8.sv
// ram_arbiter_128x8: clears a 128x8 single-port RAM after reset, then round-robin shares it between two clients
module ram_arbiter_128x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter logic [DATA_W-1:0] INIT_VAL = 8'h00
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              init_done_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_en_o,
  input  logic [DATA_W-1:0] ram_q_i
);
  typedef enum logic {INIT, ARB} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic ptr_q, ptr_d, init_done_q, init_done_d;
  logic rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic arb, gnt0, gnt1, wr0, wr1;
  // grant, RAM port mux and next-state; ram_en is gated by reset so no write lands while it is held
  always_comb begin
    arb = state_q == ARB;
    gnt0 = arb & req0_i & (~req1_i | ~ptr_q);
    gnt1 = arb & req1_i & (~req0_i | ptr_q);
    wr0 = gnt0 & we0_i;
    wr1 = gnt1 & we1_i;
    ram_addr_o = !arb ? cnt_q : gnt0 ? addr0_i : gnt1 ? addr1_i : '0;
    ram_data_o = !arb ? INIT_VAL : wr0 ? wdata0_i : wr1 ? wdata1_i : '0;
    ram_en_o = ~reset_i & (~arb | wr0 | wr1);
    state_d = (!arb && &cnt_q) ? ARB : state_q;
    init_done_d = init_done_q | (~arb & (&cnt_q));
    cnt_d = arb ? cnt_q : cnt_q + 1'b1;
    ptr_d = gnt0 ? 1'b1 : gnt1 ? 1'b0 : ptr_q;
    rvalid0_d = gnt0 & ~we0_i;
    rvalid1_d = gnt1 & ~we1_i;
    rdata0_d = rvalid0_d ? ram_q_i : rdata0_q;
    rdata1_d = rvalid1_d ? ram_q_i : rdata1_q;
  end
  // state, sweep counter, priority pointer and registered read returns
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= INIT;
      cnt_q <= '0;
      ptr_q <= 1'b0;
      init_done_q <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      init_done_q <= init_done_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign gnt0_o = gnt0;
  assign gnt1_o = gnt1;
  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;
  assign init_done_o = init_done_q;
endmodule

// File: tb/tb_ram_arbiter_128x8.sv
// tb_ram_arbiter_128x8: directed vector bench with a behavioural RAM for ram_arbiter_128x8
module tb_ram_arbiter_128x8;
  localparam logic [7:0] IV = 8'hA5;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [6:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, init_done, ram_en;
  logic [7:0] rdata0, rdata1, ram_data, ram_q;
  logic [6:0] ram_addr;
  logic [7:0] mem [128];
  int errs = 0, checks = 0;

  ram_arbiter_128x8 #(.DATA_W(8), .ADDR_W(7), .INIT_VAL(IV)) dut (
    .clk_i(clk), .reset_i(reset),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata0_o(rdata0), .rdata1_o(rdata1), .init_done_o(init_done),
    .ram_data_o(ram_data), .ram_addr_o(ram_addr), .ram_en_o(ram_en), .ram_q_i(ram_q)
  );

  always #5 clk = ~clk;
  assign ram_q = mem[ram_addr];
  always @(posedge clk) if (ram_en) mem[ram_addr] <= ram_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sweep();
    int bad = 0;
    for (int c = 0; c < 128; c++) begin
      #1;
      if (!ram_en || ram_addr != 7'(c) || ram_data != IV || gnt0 || gnt1 || init_done) begin
        if (bad == 0) $display("sweep cycle %0d: en=%0b addr=%0d data=%0h gnt=%0b%0b done=%0b", c, ram_en, ram_addr, ram_data, gnt0, gnt1, init_done);
        bad++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("sweep_bad_cycles", bad, 0);
    chk("init_done_after_128", init_done, 1);
  endtask

  typedef struct {
    logic r0, w0; logic [6:0] a0; logic [7:0] d0;
    logic r1, w1; logic [6:0] a1; logic [7:0] d1;
    logic g0, g1, en; logic [6:0] ra; logic [7:0] rd;
    logic v0, v1; logic [7:0] q0, q1;
  } vec_t;
  vec_t vt [16];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    vt[0]  = '{0,0, 0,8'h00, 1,1,33,8'h3C, 0,1,1,33,8'h3C, 0,0,8'hA5,8'h00};
    vt[1]  = '{1,0,33,8'h00, 0,0, 0,8'h00, 1,0,0,33,8'h00, 1,0,8'h3C,8'h00};
    vt[2]  = '{0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0, 0,8'h00, 0,0,8'h3C,8'h00};
    vt[3]  = '{0,0, 0,8'h00, 1,0,33,8'h00, 0,1,0,33,8'h00, 0,1,8'h3C,8'h3C};
    vt[4]  = '{0,0, 0,8'h00, 1,1, 5,8'h11, 0,1,1, 5,8'h11, 0,0,8'h3C,8'h3C};
    vt[5]  = '{0,0, 0,8'h00, 1,0, 5,8'h00, 0,1,0, 5,8'h00, 0,1,8'h3C,8'h11};
    vt[6]  = '{0,0, 0,8'h00, 1,0, 0,8'h00, 0,1,0, 0,8'h00, 0,1,8'h3C,8'hA5};
    vt[7]  = '{0,0, 0,8'h00, 1,1, 0,8'h77, 0,1,1, 0,8'h77, 0,0,8'h3C,8'hA5};
    vt[8]  = '{1,0, 0,8'h00, 1,0, 5,8'h00, 1,0,0, 0,8'h00, 1,0,8'h77,8'hA5};
    vt[9]  = '{1,0,33,8'h00, 1,0, 5,8'h00, 0,1,0, 5,8'h00, 0,1,8'h77,8'h11};
    vt[10] = '{1,1,10,8'hC3, 1,0,10,8'h00, 1,0,1,10,8'hC3, 0,0,8'h77,8'h11};
    vt[11] = '{1,0,10,8'h00, 1,0,10,8'h00, 0,1,0,10,8'h00, 0,1,8'h77,8'hC3};
    vt[12] = '{1,0,10,8'h00, 1,0,33,8'h00, 1,0,0,10,8'h00, 1,0,8'hC3,8'hC3};
    vt[13] = '{0,0, 0,8'h00, 1,0,33,8'h00, 0,1,0,33,8'h00, 0,1,8'hC3,8'h3C};
    vt[14] = '{1,0,33,8'h00, 1,0, 0,8'h00, 1,0,0,33,8'h00, 1,0,8'h3C,8'h3C};
    vt[15] = '{1,0, 5,8'h00, 0,0, 0,8'h00, 1,0,0, 5,8'h00, 1,0,8'h11,8'h3C};

    req0 = 1'b1; we0 = 1'b0; addr0 = 7'd127;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_rdata", {rdata0, rdata1}, 0);
    chk("rst_init_done", init_done, 0);
    @(negedge clk);
    reset = 1'b0;
    sweep();
    #1;
    chk("first_arb_gnt0", gnt0, 1);
    chk("first_arb_addr", ram_addr, 127);
    chk("first_arb_en", ram_en, 0);
    @(posedge clk);
    #1;
    chk("init_read_rvalid0", rvalid0, 1);
    chk("init_read_rdata0", rdata0, IV);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      {req0, we0, addr0, wdata0} = {vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0};
      {req1, we1, addr1, wdata1} = {vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1};
      #1;
      chk($sformatf("v%0d_gnt", i), {gnt0, gnt1}, {vt[i].g0, vt[i].g1});
      chk($sformatf("v%0d_ram_en", i), ram_en, vt[i].en);
      chk($sformatf("v%0d_ram_addr", i), ram_addr, vt[i].ra);
      if (vt[i].en || !(vt[i].g0 || vt[i].g1)) chk($sformatf("v%0d_ram_data", i), ram_data, vt[i].rd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rvalid", i), {rvalid0, rvalid1}, {vt[i].v0, vt[i].v1});
      chk($sformatf("v%0d_rdata", i), {rdata0, rdata1}, {vt[i].q0, vt[i].q1});
    end

    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'd36; req1 = 1'b0;
    #1;
    chk("mid_gnt0", gnt0, 1);
    chk("mid_addr", ram_addr, 36);
    #1;
    reset = 1'b1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'd36; wdata1 = 8'hFF;
    #1;
    chk("mid_rst_ram_en", ram_en, 0);
    chk("mid_rst_gnt", {gnt0, gnt1}, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_rvalid0", rvalid0, 0);
    chk("mid_rst_rdata0", rdata0, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_ram_en_edge", ram_en, 0);
    @(negedge clk);
    reset = 1'b0;
    sweep();
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      chk($sformatf("alt%0d_gnt", i), {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      @(posedge clk);
      #1;
      chk($sformatf("alt%0d_rvalid0", i), rvalid0, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) chk($sformatf("alt%0d_rdata0", i), rdata0, (i == 0) ? IV : 8'hFF);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter_128x8.md
# ram_arbiter_128x8

Two-requester controller for the 128x8 single-port RAM. It clears the whole array to a programmable value after every reset, then shares the RAM's single port between two clients with round-robin arbitration. Each cycle it issues at most one read or write, and it returns read data registered one cycle after the grant. The block sits between the two client datapaths and the RAM's data/addr/ram_en inputs and q output.

## Interface
- DATA_W, 8, RAM word width
- ADDR_W, 7, RAM address width; depth is 2**ADDR_W = 128
- INIT_VAL, 8'h00, value written to every word during the init sweep

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request from client 0 / 1; held until granted
- we0 / we1  in  1  1 = write, 0 = read; valid while reqN is high
- addr0 / addr1  in  ADDR_W  client address
- wdata0 / wdata1  in  DATA_W  client write data
- gnt0 / gnt1  out  1  combinational grant; the access executes in this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdataN holds the read result
- rdata0 / rdata1  out  DATA_W  registered read data
- init_done  out  1  high once the clear sweep has finished
- ram_data  out  DATA_W  to RAM data
- ram_addr  out  ADDR_W  to RAM addr
- ram_en  out  1  to RAM ram_en (write enable)
- ram_q  in  DATA_W  from RAM q (combinational read of ram_addr)

## Operation
- **States:** INIT and ARB. Reset forces INIT, init counter = 0, priority pointer = 0, and clears rvalid0/1, rdata0/1 and init_done.
- **INIT:**
  - ram_addr = counter, ram_data = INIT_VAL, ram_en = 1; gnt0/1 = 0.
  - The counter increments each clock.
  - When counter = 127 at an edge, the next state is ARB, init_done is set to 1 and the counter wraps to 0.
- **ARB, no request:** ram_en = 0, ram_addr = 0, ram_data = 0, no grant.
- **ARB, one request:** reqN alone gives gntN = 1.
- **ARB, both requests:** gnt goes to the requester equal to the pointer.
- **Pointer:** after a grant to N, the pointer becomes 1-N on the next edge. With no grant, the pointer holds.
- **Granted write:** ram_addr = addrN, ram_data = wdataN, ram_en = 1. The RAM updates at the end of the cycle.
- **Granted read:** ram_addr = addrN, ram_en = 0. ram_q is captured into rdataN at the edge, and rvalidN = 1 for the following cycle only.
- **rdataN between reads:** holds its value until the next read by the same client.
- **Request behaviour:**
  - reqN deasserting before a grant is legal; nothing executes.
  - An ungranted requester keeps its inputs stable.
- **Reset gating:** ram_en is forced to 0 while reset is high, so no RAM write occurs during reset.
- **Requests during INIT:** ignored, with no grant. They are served once ARB is reached.

## Timing
- **Reset values:**
  - gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0, init_done = 0.
  - ram_en = 0 while reset is asserted.
  - After reset release, ram_addr = 0 and ram_data = INIT_VAL.
- **Init sweep:**
  - Occupies exactly 128 cycles after reset release, writing addr 0..127.
  - init_done rises on the 128th edge after release.
  - The first grant is possible in cycle 128.
- **Grant:** same cycle as the request in ARB (zero latency). Write data is in the RAM after that edge.
- **Read latency:** 1 cycle from grant to rvalidN/rdataN.
- **Throughput:** 1 access per cycle. With both clients continuously requesting, grants alternate 0,1,0,1…
- **Read-after-write:** a read of the same address by either client in the cycle after the write returns the new data.
- **Reset mid-operation:**
  - The in-flight rvalid is dropped.
  - A write in the reset cycle is suppressed.
  - The pointer returns to 0 and the sweep restarts from address 0.

## Test plan
- **Init sweep:** release reset with INIT_VAL = 8'hA5 -> ram_en high for exactly 128 cycles with addr 0..127; init_done rises at edge 128; a client-0 read of addr 127 returns 8'hA5 with rvalid0 one cycle after gnt0.
- **Simultaneous requests:** both clients request in the first ARB cycle -> gnt0 first, gnt1 the next cycle. Both held continuously -> alternating grants, never two in one cycle.
- **Write then read:** client 1 writes 8'h3C to addr 33, then client 0 reads addr 33 the next cycle -> rdata0 = 8'h3C and rvalid0 is a single-cycle pulse.
- **Single requester:** only client 1 requests for 5 cycles -> gnt1 every cycle; pointer fairness does not stall a lone requester.
- **Requests during INIT:** req0 asserted from reset release -> no gnt0 until cycle 128; granted in cycle 128.
- **Reset mid-operation:** assert reset during a read grant at addr 36 -> rvalid0 stays 0, ram_en is 0 during reset, and the sweep restarts at addr 0 after release.
